// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [1:0] {S_ASSERT, S_PERIPH, S_GUARD, S_RUN} rseq_state_t;

    localparam int RSEQ_CNT_W = 32;

endpackage

// File: rtl/button_debounce.sv
// Push-button synchronizer and stability debouncer; pressed is active-high
// regardless of the raw button polarity.
module button_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pressed
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic IDLE_LEVEL = BTN_ACTIVE_LOW ? 1'b1 : 1'b0;

    logic            sync_a;
    logic            sync_b;
    logic            level;
    logic [DB_W-1:0] stable_cnt;

    assign level = BTN_ACTIVE_LOW ? ~sync_b : sync_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_a     <= IDLE_LEVEL;
            sync_b     <= IDLE_LEVEL;
            stable_cnt <= '0;
            pressed    <= 1'b0;
        end else begin
            sync_a <= btn_raw;
            sync_b <= sync_a;
            // Any cycle agreeing with the accepted level restarts the stability window.
            if (level == pressed) begin
                stable_cnt <= '0;
            end else if (stable_cnt == DB_LAST) begin
                stable_cnt <= '0;
                pressed    <= level;
            end else begin
                stable_cnt <= stable_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Ordered reset release: peripherals first, then the core, then the watchdog hold.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned ASSERT_CYCLES   = 1024,
    parameter int unsigned PERIPH_CYCLES   = 4096,
    parameter int unsigned GUARD_CYCLES    = 65536,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter bit          BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sys_reset_req,
    input  logic       btn_raw,
    output logic       periph_rst,
    output logic       core_rst,
    output logic       wd_hold,
    output logic       busy,
    output logic [7:0] reset_count
);

    localparam logic [RSEQ_CNT_W-1:0] ASSERT_LAST = RSEQ_CNT_W'(ASSERT_CYCLES - 1);
    localparam logic [RSEQ_CNT_W-1:0] PERIPH_LAST = RSEQ_CNT_W'(PERIPH_CYCLES - 1);
    localparam logic [RSEQ_CNT_W-1:0] GUARD_LAST  = RSEQ_CNT_W'(GUARD_CYCLES - 1);

    rseq_state_t           state;
    rseq_state_t           nxt_state;
    logic [RSEQ_CNT_W-1:0] cnt;
    logic                  btn_pressed;
    logic                  req;
    logic                  entry;

    button_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
    ) u_debounce (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_raw),
        .pressed (btn_pressed)
    );

    assign req = sys_reset_req | btn_pressed;

    always_comb begin
        nxt_state = state;
        entry     = 1'b0;
        case (state)
            S_ASSERT: if (!req && cnt == ASSERT_LAST) nxt_state = S_PERIPH;
            S_PERIPH: begin
                if (req) begin
                    nxt_state = S_ASSERT;
                    entry     = 1'b1;
                end else if (cnt == PERIPH_LAST) begin
                    nxt_state = S_GUARD;
                end
            end
            S_GUARD: begin
                if (req) begin
                    nxt_state = S_ASSERT;
                    entry     = 1'b1;
                end else if (cnt == GUARD_LAST) begin
                    nxt_state = S_RUN;
                end
            end
            default: begin
                if (req) begin
                    nxt_state = S_ASSERT;
                    entry     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_ASSERT;
            cnt         <= '0;
            reset_count <= 8'd0;
            periph_rst  <= 1'b1;
            core_rst    <= 1'b1;
            wd_hold     <= 1'b1;
            busy        <= 1'b1;
        end else begin
            state <= nxt_state;
            // The counter is parked in RUN so it never wraps while idle.
            if (nxt_state != state || (state == S_ASSERT && req) || state == S_RUN)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;
            if (entry && reset_count != 8'hFF)
                reset_count <= reset_count + 8'd1;
            periph_rst <= (nxt_state == S_ASSERT);
            core_rst   <= (nxt_state == S_ASSERT) || (nxt_state == S_PERIPH);
            wd_hold    <= (nxt_state != S_RUN);
            busy       <= (nxt_state != S_RUN);
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with short sequencing and debounce windows.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       sys_reset_req;
    logic       btn_raw;
    logic       periph_rst;
    logic       core_rst;
    logic       wd_hold;
    logic       busy;
    logic [7:0] reset_count;

    int tests_run = 0;
    int tests_failed = 0;

    reset_sequencer #(
        .ASSERT_CYCLES   (4),
        .PERIPH_CYCLES   (8),
        .GUARD_CYCLES    (16),
        .DEBOUNCE_CYCLES (5),
        .BTN_ACTIVE_LOW  (1'b1)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .sys_reset_req (sys_reset_req),
        .btn_raw       (btn_raw),
        .periph_rst    (periph_rst),
        .core_rst      (core_rst),
        .wd_hold       (wd_hold),
        .busy          (busy),
        .reset_count   (reset_count)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] outs();
        return {28'd0, periph_rst, core_rst, wd_hold, busy};
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        sys_reset_req = 1'b0;
        btn_raw = 1'b1;
        tick(3);
        check("reset_outs", outs(), 32'hF);
        check("reset_count_rst", {24'd0, reset_count}, 32'd0);

        // Power-up: rst released after edge 0.
        rst = 1'b0;
        tick(3);
        check("pu_e3", outs(), 32'hF);
        tick(1);
        check("pu_e4_periph", outs(), 32'h7);
        tick(7);
        check("pu_e11", outs(), 32'h7);
        tick(1);
        check("pu_e12_core", outs(), 32'h3);
        tick(15);
        check("pu_e27", outs(), 32'h3);
        tick(1);
        check("pu_e28_run", outs(), 32'h0);
        check("pu_count", {24'd0, reset_count}, 32'd0);

        // Watchdog pulse of 3 cycles while running.
        sys_reset_req = 1'b1;
        tick(1);
        check("wd_assert", outs(), 32'hF);
        check("wd_count", {24'd0, reset_count}, 32'd1);
        tick(2);
        sys_reset_req = 1'b0;
        tick(3);
        check("wd_hold3", outs(), 32'hF);
        tick(1);
        check("wd_periph", outs(), 32'h7);
        check("wd_count2", {24'd0, reset_count}, 32'd1);
        tick(8);
        check("wd_core", outs(), 32'h3);
        tick(16);
        check("wd_run", outs(), 32'h0);

        // Button held for 10 cycles: press sampled at edge 1, outputs high at edge 8.
        btn_raw = 1'b0;
        tick(7);
        check("btn_e7", outs(), 32'h0);
        tick(1);
        check("btn_e8", outs(), 32'hF);
        check("btn_count", {24'd0, reset_count}, 32'd2);
        tick(2);
        btn_raw = 1'b1;
        tick(10);
        check("btn_rel_e20", outs(), 32'hF);
        tick(1);
        check("btn_rel_e21", outs(), 32'h7);
        check("btn_count2", {24'd0, reset_count}, 32'd2);
        tick(24);
        check("btn_run", outs(), 32'h0);

        // 3-cycle glitch is rejected.
        btn_raw = 1'b0;
        tick(3);
        btn_raw = 1'b1;
        tick(12);
        check("glitch_outs", outs(), 32'h0);
        check("glitch_count", {24'd0, reset_count}, 32'd2);

        // Re-entry from GUARD.
        sys_reset_req = 1'b1;
        tick(1);
        sys_reset_req = 1'b0;
        check("re_count3", {24'd0, reset_count}, 32'd3);
        tick(4);
        check("re_periph", outs(), 32'h7);
        tick(8);
        check("re_guard", outs(), 32'h3);
        tick(3);
        sys_reset_req = 1'b1;
        tick(1);
        check("re_assert", outs(), 32'hF);
        check("re_count4", {24'd0, reset_count}, 32'd4);
        tick(1);
        check("re_count_once", {24'd0, reset_count}, 32'd4);
        sys_reset_req = 1'b0;
        tick(4);
        check("re_periph2", outs(), 32'h7);

        // 260 pulses, each landing in PERIPH, saturate the entry count.
        for (int i = 0; i < 260; i++) begin
            sys_reset_req = 1'b1;
            tick(1);
            sys_reset_req = 1'b0;
            tick(5);
            if (i == 249) check("sat_254", {24'd0, reset_count}, 32'd254);
            if (i == 250) check("sat_255", {24'd0, reset_count}, 32'd255);
        end
        check("sat_final", {24'd0, reset_count}, 32'd255);
        check("sat_periph", outs(), 32'h7);

        // rst in the middle of PERIPH.
        rst = 1'b1;
        tick(1);
        check("midrst_outs", outs(), 32'hF);
        check("midrst_count", {24'd0, reset_count}, 32'd0);
        rst = 1'b0;
        tick(4);
        check("midrst_restart", outs(), 32'h7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
